// File: rtl/clkdiv_ctrl_if.sv
// Divide-ratio load handshake: level request plus one-cycle ack/err pulses and busy.
// Requester holds div_req until it sees ack or err; busy blocks new requests while a ratio is pending.
interface clkdiv_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             div_req;
  logic [CNT_W-1:0] div_val;
  logic             div_ack;
  logic             div_err;
  logic             busy;

  modport master (
    output div_req,
    output div_val,
    input  div_ack,
    input  div_err,
    input  busy
  );

  modport slave (
    input  div_req,
    input  div_val,
    output div_ack,
    output div_err,
    output busy
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider: registered tick/out, ratio loads ack/err one cycle after sampling.
// New ratios apply at the next period wrap (or at once when idle); CLKDIV_DUTY50_EN selects ~50% duty out.
module clkdiv_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  clkdiv_ctrl_if.slave  div,
  output logic          out,
  output logic          tick
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] MIN_N = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_N = CNT_W'(3);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_active_q, n_active_d;
  logic [CNT_W-1:0] n_pend_q, n_pend_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             out_d, tick_d;
  logic             sample, legal, wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      n_active_q <= RST_N;
      n_pend_q   <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      out        <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      n_active_q <= n_active_d;
      n_pend_q   <= n_pend_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      out        <= out_d;
      tick       <= tick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    n_active_d = n_active_q;
    n_pend_d   = n_pend_q;
    busy_d     = busy_q;

    // Ack/err pulse cycles also block sampling, so a held request is not re-taken.
    sample = div.div_req && !busy_q && !ack_q && !err_q;
    legal  = div.div_val >= MIN_N;
    ack_d  = sample && legal;
    err_d  = sample && !legal;
    wrap   = count_q == n_active_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          count_d = '0;
          if (busy_q) begin
            n_active_d = n_pend_q;
            busy_d     = 1'b0;
          end
        end else if (wrap) begin
          count_d = '0;
          if (busy_q) begin
            n_active_d = n_pend_q;
            busy_d     = 1'b0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // Ratios accepted while not staying in RUN take effect immediately; otherwise wait for the wrap.
    if (ack_d) begin
      if (state_q == IDLE || !en) begin
        n_active_d = div.div_val;
      end else begin
        n_pend_d = div.div_val;
        busy_d   = 1'b1;
      end
    end

    tick_d = (state_d == RUN) && (count_d == '0);
`ifdef CLKDIV_DUTY50_EN
    out_d = (state_d == RUN) &&
            ({1'b0, count_d} < (({1'b0, n_active_d} + 1'b1) >> 1));
`else
    out_d = tick_d;
`endif
  end

  assign div.div_ack = ack_q;
  assign div.div_err = err_q;
  assign div.busy    = busy_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed-vector bench for clkdiv_ctrl: each row drives one cycle and queues the outputs
// expected in the following cycle; a monitor pops and compares every cycle.
module tb_clkdiv_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic out, tick;

  clkdiv_ctrl_if #(.CNT_W(8)) dif ();

  clkdiv_ctrl #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .div   (dif.slave),
    .out   (out),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit tick;
    bit out;
    bit ack;
    bit err;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   row_id = 0;

  task automatic chk(input string name, input int id, input logic act, input bit want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%b want=%0b", name, id, act, want);
    end
  endtask

  // Inputs for one cycle, then expected tick, out (divider), out (duty build), ack, err, busy next cycle.
  task automatic row(input bit r, input bit e, input bit q, input int v,
                     input bit t, input bit o, input bit od,
                     input bit a, input bit er, input bit b);
    exp_t x;
    @(posedge clk);
    #1;
    reset       = r;
    en          = e;
    dif.div_req = q;
    dif.div_val = 8'(v);
    x.id   = row_id;
    x.tick = t;
`ifdef CLKDIV_DUTY50_EN
    x.out  = od;
`else
    x.out  = o;
`endif
    x.ack  = a;
    x.err  = er;
    x.busy = b;
    exp_q.push_back(x);
    row_id++;
  endtask

  always begin
    exp_t x;
    @(posedge clk);
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      @(negedge clk);
      chk("tick", x.id, tick, x.tick);
      chk("out",  x.id, out,  x.out);
      chk("ack",  x.id, dif.div_ack, x.ack);
      chk("err",  x.id, dif.div_err, x.err);
      chk("busy", x.id, dif.busy, x.busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    dif.div_req = 1'b0;
    dif.div_val = 8'd0;
    //   rst en req val   tick out outd ack err busy
    row(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);   // reset -> idle, all low
    // default N=3 running
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);   // c0
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 0);   // c1
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);   // c2
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    // illegal ratios 1 and 0
    row(0, 1, 1, 1,   1, 1, 1, 0, 1, 0);
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 0);
    row(0, 1, 1, 0,   0, 0, 0, 0, 1, 0);
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 0);   // c1
    // load 5 at count=1: current period finishes at 3
    row(0, 1, 1, 5,   0, 0, 0, 1, 0, 1);   // c2, ack
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);   // c0 N=5, busy clears
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);   // c0
    // load 4, then hold request for 6 while busy
    row(0, 1, 1, 4,   0, 0, 1, 1, 0, 1);   // c1
    row(0, 1, 1, 6,   0, 0, 1, 0, 0, 1);   // c2
    row(0, 1, 1, 6,   0, 0, 0, 0, 0, 1);   // c3
    row(0, 1, 1, 6,   0, 0, 0, 0, 0, 1);   // c4
    row(0, 1, 1, 6,   1, 1, 1, 0, 0, 0);   // c0 N=4
    row(0, 1, 1, 6,   0, 0, 1, 1, 0, 1);   // c1, 6 acked
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 1);   // c2
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 1);   // c3
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);   // c0 N=6
    // pend 7 then reset at count=2
    row(0, 1, 1, 7,   0, 0, 1, 1, 0, 1);   // c1
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 1);   // c2
    row(1, 1, 1, 9,   0, 0, 0, 0, 0, 0);   // reset dominates
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);   // c0 N=3, pending dropped
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 0);   // c1
    // en drop mid-period: no drain
    row(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // load 4 while idle: applied at once, busy stays low
    row(0, 0, 1, 4,   0, 0, 0, 1, 0, 0);
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);   // c0 N=4
    row(0, 1, 0, 0,   0, 0, 1, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);   // c0
    // pend 2 then drop en: applied on idle entry
    row(0, 1, 1, 2,   0, 0, 1, 1, 0, 1);   // c1
    row(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);   // idle, busy clears
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);   // c0 N=2
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);
    // same ratio reloaded: acked like any other
    row(0, 1, 1, 2,   0, 0, 0, 1, 0, 1);   // c1
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);   // c0, busy clears
    row(0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0,   1, 1, 1, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, default 8, width of the divide-ratio value and internal period counter.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 SHALL have port: en  input  1  run enable; 1 = divider runs, 0 = divider idles.
REQ-005 SHALL have port: div_req  input  1  level request to load a new divide ratio.
REQ-006 SHALL have port: div_val  input  CNT_W  requested ratio N; legal range 2..2^CNT_W-1.
REQ-007 SHALL have port: div_ack  output  1  one-cycle pulse, request accepted.
REQ-008 SHALL have port: div_err  output  1  one-cycle pulse, request rejected (illegal N).
REQ-009 SHALL have port: busy  output  1  accepted ratio pending, not yet applied.
REQ-010 SHALL have port: out  output  1  divided output, registered.
REQ-011 SHALL have port: tick  output  1  one-cycle pulse marking each period start, registered.

Function
REQ-012 SHALL implement states IDLE and RUN; in IDLE, count = 0, out = 0, tick = 0.
REQ-013 SHALL move IDLE->RUN on the first edge with en=1; the first RUN cycle has count=0.
REQ-014 In RUN, count SHALL increment by 1 per cycle and wrap from N_active-1 to 0; no other values are reachable.
REQ-015 tick SHALL be 1 exactly in RUN cycles where count = 0 (one pulse per N_active cycles).
REQ-016 Without the duty macro, out SHALL equal tick: high 1 cycle, low N_active-1 cycles per period.
REQ-017 SHALL move RUN->IDLE on the edge where en=0 is sampled; count, out, and tick are 0 in the following cycle. No period drain occurs.
REQ-018 A request SHALL be sampled when div_req=1, busy=0, div_ack=0, and div_err=0.
REQ-019 If a sampled div_val < 2, div_err SHALL pulse in the next cycle; N_active and busy are unchanged.
REQ-020 If a sampled div_val is legal, div_ack SHALL pulse in the next cycle and the value SHALL be stored as N_pend.
REQ-021 In RUN, busy SHALL be 1 from the ack cycle until N_pend is applied.
REQ-022 In RUN, N_pend SHALL be applied when count wraps to 0; the new period uses the new N, and busy clears in that same cycle.
REQ-023 In IDLE, N_pend SHALL be applied in the ack cycle and busy SHALL stay 0.
REQ-024 div_req while busy=1 SHALL be ignored with no ack/err; the requester holds div_req.
REQ-025 If en falls while busy=1, N_pend SHALL be applied on entry to IDLE and busy SHALL clear.
REQ-026 A request loading the same N as N_active SHALL be acked and treated identically to any legal request.

Reset
REQ-027 reset=1 SHALL force, in the next cycle: state IDLE, count 0, N_active 3, N_pend discarded, and out, tick, div_ack, div_err, busy all 0.
REQ-028 reset SHALL dominate en and div_req in the same cycle; reset mid-period SHALL abort the period with no partial pulse.

Configuration
REQ-029 Macro CLKDIV_DUTY50_EN defined: out SHALL be 1 for RUN cycles with count < ceil(N_active/2) and 0 otherwise. N=3 gives high 2, low 1; N=4 gives high 2, low 2.
REQ-030 Macro CLKDIV_DUTY50_EN undefined: out SHALL follow REQ-016; tick is unaffected either way.

Verification
REQ-031 Reset, en=1, no request -> tick/out period 3 cycles; out pattern 1,0,0 repeating (macro off).
REQ-032 While running N=3, request 5 at count=1 -> ack next cycle; busy high until wrap; current period stays 3; following periods 5 cycles.
REQ-033 Request div_val=1, then div_val=0 -> div_err pulse each time; no ack; period stays 3; busy stays 0.
REQ-034 Request 4 accepted with busy=1, then second request 6 held -> no response until busy clears; 6 then acked.
REQ-035 Assert reset at count=2 with N_pend=7 pending -> all outputs 0 next cycle; after release, en=1 gives period 3.
REQ-036 Macro on, N=5 -> out 1,1,1,0,0 repeating; en dropped mid-period -> out 0 the next cycle.
